mul_issue_ctrl: RTL

//  Issue/retire controller wrapped around the 2-stage Booth/Wallace multiplier (mul) in the EXE stage.
//  - Accepts mul.w / mulh.w / mulh.wu ops over valid/ready and drives the multiplier's x/y/mul_signed inputs.
//  - Tracks each op through the multiplier's fixed latency, then selects the 32-bit result half.
//  - Buffers results in an in-order FIFO so back-pressure never drops a multiplier result.

---
 rtl/mul_issue_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue/retire controller around the 2-stage Booth/Wallace mul unit.
// Accepted ops are tracked through the fixed mul latency, and the selected result word
// is queued in an in-order FIFO. Credit-based in_ready means a result is never dropped.
// Optional build macro MUL_PERF_CNT_EN adds the perf_issue/perf_stall counters.
module mul_issue_ctrl #(
  parameter int MUL_LAT   = 1,
  parameter int OUT_DEPTH = 4,
  parameter int TAG_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      mul_x,
  output logic [31:0]      mul_y,
  output logic             mul_signed,
  input  logic [63:0]      mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
`ifdef MUL_PERF_CNT_EN
  ,
  output logic [31:0]      perf_issue,
  output logic [31:0]      perf_stall
`endif
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + MUL_LAT + 1) + 1;

  logic [MUL_LAT-1:0] pipe_valid_q, pipe_valid_d;
  logic [MUL_LAT-1:0] pipe_hi_q, pipe_hi_d;
  logic [TAG_W-1:0]   pipe_tag_q [MUL_LAT];
  logic [TAG_W-1:0]   pipe_tag_d [MUL_LAT];

  logic [31:0]        mem_data_q [OUT_DEPTH];
  logic [TAG_W-1:0]   mem_tag_q  [OUT_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]   inflight_cnt;

  logic               accept;
  logic               push;
  logic               pop;
  logic [31:0]        push_data;

  // The multiplier sees the offered operands directly; it runs whether or not we accept.
  assign mul_x      = in_src1;
  assign mul_y      = in_src2;
  assign mul_signed = (in_op != 2'b10);

  // Credit: only registered occupancy counts, so a pop frees a slot one cycle later.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < MUL_LAT; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(pipe_valid_q[i]);
    end
    in_ready = ~reset & ~flush & ((inflight_cnt + fifo_cnt_q) < CNT_W'(OUT_DEPTH));
    accept   = in_valid & in_ready;
  end

  // Tracking pipe mirrors the mul register stages and never stalls; flush kills every stage.
  always_comb begin
    pipe_valid_d = '0;
    pipe_hi_d    = '0;
    for (int i = 0; i < MUL_LAT; i++) begin
      pipe_tag_d[i] = '0;
    end
    pipe_valid_d[0] = accept;
    pipe_hi_d[0]    = (in_op == 2'b01) || (in_op == 2'b10);
    pipe_tag_d[0]   = in_tag;
    for (int i = 1; i < MUL_LAT; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_hi_d[i]    = pipe_hi_q[i-1];
      pipe_tag_d[i]   = pipe_tag_q[i-1];
    end
    if (flush) begin
      pipe_valid_d = '0;
    end
  end

  assign push      = pipe_valid_q[MUL_LAT-1] & ~flush & ~reset;
  assign out_valid = (fifo_cnt_q != '0) & ~reset;
  assign pop       = out_valid & out_ready;
  assign push_data = pipe_hi_q[MUL_LAT-1] ? mul_result[63:32] : mul_result[31:0];

  // FIFO pointers and occupancy; push and pop may coincide at any fill level.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid_q <= '0;
      pipe_hi_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_hi_q    <= pipe_hi_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  // Tags and FIFO payload need no reset; they are only looked at behind a valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MUL_LAT; i++) begin
      pipe_tag_q[i] <= pipe_tag_d[i];
    end
    if (push) begin
      mem_data_q[wr_ptr_q] <= push_data;
      mem_tag_q[wr_ptr_q]  <= pipe_tag_q[MUL_LAT-1];
    end
  end

  assign out_result = out_valid ? mem_data_q[rd_ptr_q] : '0;
  assign out_tag    = out_valid ? mem_tag_q[rd_ptr_q]  : '0;

  // The credit scheme should make a push into a full FIFO without a same-cycle pop impossible.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !pop && (fifo_cnt_q == CNT_W'(OUT_DEPTH))));
    end
  end

`ifdef MUL_PERF_CNT_EN
  logic [31:0] perf_issue_q, perf_issue_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Free-running wrap-around counters of accepted ops and blocked offer cycles.
  always_comb begin
    perf_issue_d = perf_issue_q + 32'(accept);
    perf_stall_d = perf_stall_q + 32'(in_valid & ~in_ready & ~flush);
  end

  // Perf counters are cleared by reset only; flush leaves them running.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_issue = perf_issue_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
